// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
// Multiplexed seven-segment driver for NUM_DIGITS common-anode digits.
// A prescaler and a digit counter generate the scan timing. Display data is
// copied into shadow registers once per frame, so a digit never shows a
// half-updated value. The driver also blanks between digits, and supports
// per-digit decimal point, per-digit blanking and leading-zero suppression.
//
// Optional feature: define SSD_DIMMING_EN to add the brightness_i port. This
// enables 16-step PWM dimming of the active window.
//
// Ports
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   en_i            1 = scan, 0 = display dark with counters held at 0
//   digits_i        hex nibble per digit, digit i = [4i+3:4i], digit 0 rightmost
//   dp_i            1 = light decimal point of digit i
//   blank_i         1 = force digit i dark
//   lz_suppress_i   1 = blank leading zeros
//   brightness_i    (SSD_DIMMING_EN only) PWM duty, 15 = full, 0 = 1/16
//   ssd_cathodes_o  active-low {a,b,c,d,e,f,g,dp}
//   anodes_o        active-low digit enables, one-hot-low
//   frame_start_o   1-cycle pulse: snapshot taken, frame begins
module ssd_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    lz_suppress_i,
`ifdef SSD_DIMMING_EN
    input  logic [3:0]              brightness_i,
`endif
    output logic [7:0]              ssd_cathodes_o,
    output logic [NUM_DIGITS-1:0]   anodes_o,
    output logic                    frame_start_o
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [IW-1:0] digitIdx_q, digitIdx_d;

    logic [4*NUM_DIGITS-1:0] shadowDigits_q;
    logic [NUM_DIGITS-1:0]   shadowDp_q;
    logic [NUM_DIGITS-1:0]   shadowBlank_q;
    logic                    shadowLz_q;

    logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
    logic [7:0]            cathodes_q, cathodes_d;
    logic                  frameStart_q;

    logic                    snapshotTake;
    logic [4*NUM_DIGITS-1:0] effDigits;
    logic [NUM_DIGITS-1:0]   effDp;
    logic [NUM_DIGITS-1:0]   effBlank;
    logic                    effLz;
    logic [NUM_DIGITS:0]     zeroAbove;
    logic [NUM_DIGITS-1:0]   digitDark;
    logic [3:0]              curNib;
    logic                    pwmOn;

    // Segment patterns for hex 0-F, ordered abcdefg, active-low.
    function automatic logic [6:0] segOf(input logic [3:0] nib);
        case (nib)
            4'h0: segOf = 7'b0000001;
            4'h1: segOf = 7'b1001111;
            4'h2: segOf = 7'b0010010;
            4'h3: segOf = 7'b0000110;
            4'h4: segOf = 7'b1001100;
            4'h5: segOf = 7'b0100100;
            4'h6: segOf = 7'b0100000;
            4'h7: segOf = 7'b0001111;
            4'h8: segOf = 7'b0000000;
            4'h9: segOf = 7'b0000100;
            4'hA: segOf = 7'b0001000;
            4'hB: segOf = 7'b1100000;
            4'hC: segOf = 7'b0110001;
            4'hD: segOf = 7'b1000010;
            4'hE: segOf = 7'b0110000;
            default: segOf = 7'b0111000;
        endcase
    endfunction

    // A frame begins at slot 0, prescaler 0. The shadow copy is taken on that same edge.
    assign snapshotTake = en_i && (prescaler_q == '0) && (digitIdx_q == '0);

    // Prescaler and digit counter. Disabling the scan parks both at zero,
    // so re-enabling always starts a clean frame with a fresh snapshot.
    always_comb begin
        prescaler_d = prescaler_q;
        digitIdx_d  = digitIdx_q;
        if (!en_i) begin
            prescaler_d = '0;
            digitIdx_d  = '0;
        end else if (prescaler_q == P_LAST) begin
            prescaler_d = '0;
            digitIdx_d  = (digitIdx_q == I_LAST) ? '0 : digitIdx_q + 1'b1;
        end else begin
            prescaler_d = prescaler_q + 1'b1;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prescaler_q <= '0;
            digitIdx_q  <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            digitIdx_q  <= digitIdx_d;
        end
    end

    // Shadow copy of the display inputs, refreshed once per frame. Blank
    // resets to all ones, so nothing lights before the first snapshot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadowDigits_q <= '0;
            shadowDp_q     <= '0;
            shadowBlank_q  <= '1;
            shadowLz_q     <= 1'b0;
        end else if (snapshotTake) begin
            shadowDigits_q <= digits_i;
            shadowDp_q     <= dp_i;
            shadowBlank_q  <= blank_i;
            shadowLz_q     <= lz_suppress_i;
        end
    end

    // On the snapshot cycle itself, the incoming values are used directly.
    // With BLANK_CYCLES = 0, digit 0 therefore already shows the new frame's data.
    assign effDigits = snapshotTake ? digits_i      : shadowDigits_q;
    assign effDp     = snapshotTake ? dp_i          : shadowDp_q;
    assign effBlank  = snapshotTake ? blank_i       : shadowBlank_q;
    assign effLz     = snapshotTake ? lz_suppress_i : shadowLz_q;

    // Leading-zero chain, walking from the leftmost digit down. A lit decimal
    // point counts as content, so it stops suppression at and right of itself.
    always_comb begin
        zeroAbove             = '0;
        digitDark             = '0;
        zeroAbove[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeroAbove[i] = zeroAbove[i+1] && (effDigits[4*i +: 4] == 4'h0) && !effDp[i];
            digitDark[i] = effBlank[i] || (effLz && (i != 0) && zeroAbove[i]);
        end
    end

    assign curNib = effDigits[{digitIdx_q, 2'b00} +: 4];

`ifdef SSD_DIMMING_EN
    logic [3:0] shadowBright_q;
    logic [3:0] effBright;
    logic [3:0] pwmCnt_q;

    // Brightness is captured with the rest of the frame data. The PWM
    // counter runs freely and does not depend on the scan position.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadowBright_q <= 4'hF;
            pwmCnt_q       <= 4'h0;
        end else begin
            pwmCnt_q <= pwmCnt_q + 4'h1;
            if (snapshotTake) begin
                shadowBright_q <= brightness_i;
            end
        end
    end

    assign effBright = snapshotTake ? brightness_i : shadowBright_q;
    assign pwmOn     = (pwmCnt_q <= effBright);
`else
    assign pwmOn = 1'b1;
`endif

    // Next-output computation. The first BLANK_CYCLES clocks of each slot
    // stay dark. This gives the previous digit's segments time to discharge
    // before the next anode turns on, which prevents ghosting.
    always_comb begin
        anodes_d   = '1;
        cathodes_d = 8'hFF;
        if (en_i && (prescaler_q >= P_BLANK) && !digitDark[digitIdx_q] && pwmOn) begin
            anodes_d[digitIdx_q] = 1'b0;
            cathodes_d           = {segOf(curNib), ~effDp[digitIdx_q]};
        end
    end

    // Registered pin drivers. They go dark immediately on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            anodes_q     <= '1;
            cathodes_q   <= 8'hFF;
            frameStart_q <= 1'b0;
        end else begin
            anodes_q     <= anodes_d;
            cathodes_q   <= cathodes_d;
            frameStart_q <= snapshotTake;
        end
    end

    assign anodes_o       = anodes_q;
    assign ssd_cathodes_o = cathodes_q;
    assign frame_start_o  = frameStart_q;

endmodule
